// File: rtl/nn_pll_pkg.sv
// Shared fixed-point widths, ratio type, FSM states and clamp helper for the
// fractional-N PLL divide-ratio blocks.
package nn_pll_pkg;

  localparam int IW_DEF = 4;
  localparam int FW_DEF = 4;

  typedef logic [IW_DEF+FW_DEF-1:0] ratio_fx_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int clamp_ratio(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/dsm_acc.sv
// One FW-bit accumulate-with-carry stage; the carry and the post-add value are
// exposed combinationally so a following stage can use them in the same cycle.
module dsm_acc
  import nn_pll_pkg::*;
#(
  parameter int FW = FW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [FW-1:0] din,
  output logic [FW-1:0] acc_nxt,
  output logic          carry
);

  logic [FW-1:0] acc_q, acc_d;
  logic [FW:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, din};
    carry   = sum[FW];
    acc_nxt = sum[FW-1:0];
    acc_d   = en ? sum[FW-1:0] : acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/nfrac_dsm.sv
// Fractional-N divide-ratio generator. First-order accumulator by default;
// define NFRAC_DSM_MASH2_EN for a second-order MASH 1-1 modulator.
module nfrac_dsm
  import nn_pll_pkg::*;
#(
  parameter int IW     = IW_DEF,
  parameter int FW     = FW_DEF,
  parameter int N_INIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IW+FW-1:0] tgt,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic             en,
  output logic [IW-1:0]    n,
  output logic             n_valid,
  output logic             sat
);

  localparam int NMAX = (1 << IW) - 1;
  localparam logic [IW+FW-1:0] TGT_INIT = (IW+FW)'(N_INIT << FW);

  state_e            state_q, state_d;
  logic [IW+FW-1:0]  active_q, active_d;
  logic [IW+FW-1:0]  shadow_q, shadow_d;
  logic              shadow_full_q, shadow_full_d;
  logic [IW-1:0]     n_q, n_d;
  logic              n_valid_q, n_valid_d;
  logic              sat_q, sat_d;

  logic              hs, xfer, adv, c1, clip;
  logic [IW+FW-1:0]  tgt_eff;
  logic signed [IW+1:0] n_raw;
  int                n_raw_i, n_cl;

  assign tgt_ready = ~shadow_full_q;
  assign hs        = tgt_valid & ~shadow_full_q;
  // The first target leaves IDLE without waiting for en; later ones ride en.
  assign xfer      = shadow_full_q & ((state_q == IDLE) | en);
  assign tgt_eff   = xfer ? shadow_q : active_q;
  assign adv       = en & (state_q == RUN);

`ifdef NFRAC_DSM_MASH2_EN
  logic [FW-1:0] acc1_nxt;
  logic [FW-1:0] acc2_nxt_unused;
  logic          c2, c2_dly_q, c2_dly_d;

  dsm_acc #(.FW(FW)) u_acc1 (
    .clk(clk), .rst(rst), .en(adv), .din(tgt_eff[FW-1:0]),
    .acc_nxt(acc1_nxt), .carry(c1)
  );

  dsm_acc #(.FW(FW)) u_acc2 (
    .clk(clk), .rst(rst), .en(adv), .din(acc1_nxt),
    .acc_nxt(acc2_nxt_unused), .carry(c2)
  );

  assign c2_dly_d = adv ? c2 : c2_dly_q;

  always_ff @(posedge clk) begin
    if (rst) c2_dly_q <= 1'b0;
    else     c2_dly_q <= c2_dly_d;
  end

  always_comb begin
    n_raw = $signed({2'b00, tgt_eff[IW+FW-1:FW]})
          + $signed({{(IW+1){1'b0}}, c1})
          + $signed({{(IW+1){1'b0}}, c2})
          - $signed({{(IW+1){1'b0}}, c2_dly_q});
  end
`else
  logic [FW-1:0] acc1_nxt_unused;

  dsm_acc #(.FW(FW)) u_acc1 (
    .clk(clk), .rst(rst), .en(adv), .din(tgt_eff[FW-1:0]),
    .acc_nxt(acc1_nxt_unused), .carry(c1)
  );

  always_comb begin
    n_raw = $signed({2'b00, tgt_eff[IW+FW-1:FW]})
          + $signed({{(IW+1){1'b0}}, c1});
  end
`endif

  always_comb begin
    n_raw_i = int'(n_raw);
    n_cl    = clamp_ratio(n_raw_i, NMAX);
    clip    = (n_cl != n_raw_i);
  end

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    shadow_d      = hs ? tgt : shadow_q;
    shadow_full_d = (shadow_full_q & ~xfer) | hs;
    n_d           = n_q;
    n_valid_d     = n_valid_q;
    sat_d         = sat_q;
    if (xfer) begin
      active_d = shadow_q;
      state_d  = RUN;
      sat_d    = 1'b0;
    end
    if (adv) begin
      n_d       = IW'(n_cl);
      n_valid_d = 1'b1;
      if (clip) sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      active_q      <= TGT_INIT;
      shadow_full_q <= 1'b0;
      n_q           <= IW'(N_INIT);
      n_valid_q     <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      shadow_full_q <= shadow_full_d;
      n_q           <= n_d;
      n_valid_q     <= n_valid_d;
      sat_q         <= sat_d;
    end
  end

  // Shadow contents are qualified by shadow_full_q, so no reset is needed.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign n       = n_q;
  assign n_valid = n_valid_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_nfrac_dsm.sv
// Directed bench for nfrac_dsm: reset, first-order patterns, clamp, backpressure,
// mid-run reset; MASH 1-1 mean/range when NFRAC_DSM_MASH2_EN is defined.
module tb_nfrac_dsm;
  import nn_pll_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      tgt_valid = 1'b0;
  logic      en = 1'b0;
  ratio_fx_t tgt = '0;
  logic      tgt_ready, n_valid, sat;
  logic [3:0] n;

  int cnt_chk = 0;
  int cnt_fail = 0;

  nfrac_dsm dut (
    .clk(clk), .rst(rst), .tgt(tgt), .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready), .en(en), .n(n), .n_valid(n_valid), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    cnt_chk++;
    if (got !== exp) begin
      cnt_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present v and return just after the edge that completes the handshake.
  task automatic offer(input logic [7:0] v);
    int waited = 0;
    tgt = v;
    tgt_valid = 1'b1;
    while (!tgt_ready && waited < 20) begin
      step();
      waited++;
    end
    chk("offer_ready", int'(tgt_ready), 1);
    step();
    tgt_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[4] = '{3, 3, 3, 4};
    int sat_exp[4] = '{0, 1, 1, 1};
    int sum, fours, mn, mx;

    step(); step();
    rst = 1'b0;
    step();
    chk("rst_n", int'(n), 3);
    chk("rst_nvalid", int'(n_valid), 0);
    chk("rst_ready", int'(tgt_ready), 1);
    chk("rst_sat", int'(sat), 0);
    chk("rst_acc", int'(dut.u_acc1.acc_q), 0);
    for (int i = 0; i < 10; i++) begin
      en = i[0];
      step();
      chk("idle_n", int'(n), 3);
      chk("idle_nvalid", int'(n_valid), 0);
    end

`ifdef NFRAC_DSM_MASH2_EN
    en = 1'b0;
    offer(8'h34);
    step();
    en = 1'b1;
    sum = 0; mn = 99; mx = -1;
    for (int i = 0; i < 64; i++) begin
      step();
      sum += int'(n);
      if (int'(n) < mn) mn = int'(n);
      if (int'(n) > mx) mx = int'(n);
    end
    chk("mash_sum", sum, 208);
    chk("mash_min_ge2", int'(mn >= 2), 1);
    chk("mash_max_le5", int'(mx <= 5), 1);
    chk("mash_sat", int'(sat), 0);
`else
    // 3.25: carry every fourth update
    en = 1'b0;
    offer(8'h34);
    step();
    chk("p34_acc0", int'(dut.u_acc1.acc_q), 0);
    en = 1'b1;
    sum = 0; fours = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("p34_n", int'(n), pat[i % 4]);
      sum += int'(n);
      if (n == 4'd4) fours++;
    end
    chk("p34_sum", sum, 52);
    chk("p34_fours", fours, 4);
    chk("p34_nvalid", int'(n_valid), 1);

    // 5.0: integer ratio, en toggling
    en = 1'b0;
    offer(8'h50);
    chk("p50_frozen", int'(n), 4);
    step();
    chk("p50_frozen2", int'(n), 4);
    en = 1'b1;
    step();
    chk("p50_first", int'(n), 5);
    for (int i = 0; i < 6; i++) begin
      en = i[0];
      step();
      chk("p50_n", int'(n), 5);
      chk("p50_acc", int'(dut.u_acc1.acc_q), 0);
    end
    chk("p50_sat", int'(sat), 0);

    // 15.5: carry cycles clamp at 15
    en = 1'b0;
    offer(8'hF8);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pf8_n", int'(n), 15);
      chk("pf8_sat", int'(sat), sat_exp[i]);
    end
    en = 1'b0;
    offer(8'h20);
    chk("p20_sat_pending", int'(sat), 1);
    en = 1'b1;
    step();
    chk("p20_sat_clear", int'(sat), 0);
    chk("p20_n", int'(n), 2);

    // Backpressure: second target waits while the shadow is full
    en = 1'b0;
    tgt = 8'h40;
    tgt_valid = 1'b1;
    step();
    tgt = 8'h60;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ready_low", int'(tgt_ready), 0);
      chk("bp_n_hold", int'(n), 2);
    end
    en = 1'b1;
    step();
    chk("bp_n40", int'(n), 4);
    chk("bp_ready_high", int'(tgt_ready), 1);
    en = 1'b0;
    step();
    chk("bp_ready_low2", int'(tgt_ready), 0);
    tgt_valid = 1'b0;
    en = 1'b1;
    step();
    chk("bp_n60", int'(n), 6);
    chk("bp_ready_high2", int'(tgt_ready), 1);

    // Reset mid-run with the shadow full
    en = 1'b0;
    offer(8'h34);
    chk("mr_shadow_full", int'(tgt_ready), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_n", int'(n), 3);
    chk("mr_nvalid", int'(n_valid), 0);
    chk("mr_ready", int'(tgt_ready), 1);
    chk("mr_acc", int'(dut.u_acc1.acc_q), 0);
    chk("mr_sat", int'(sat), 0);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_idle_n", int'(n), 3);
      chk("mr_idle_nvalid", int'(n_valid), 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", cnt_chk, cnt_fail);
    $finish;
  end

endmodule
